// File: rtl/forward_hazard_unit_if.sv
// Interface bundling the ID-stage request and the hazard/forward responses of forward_hazard_unit.
// StallCount/FwdCount exist only when FWD_STATS_EN is defined.
interface forward_hazard_unit_if #(
    parameter int REG_AW = 5
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
);
    logic              ID_Valid;
    logic [REG_AW-1:0] ID_Src1;
    logic [REG_AW-1:0] ID_Src2;
    logic              ID_UsesSrc2;
    logic [REG_AW-1:0] ID_Dest;
    logic              ID_WB_En;
    logic              ID_MemRead;
    logic              Flush;
    logic              Stall;
    logic [1:0]        forwardOp1;
    logic [1:0]        forwardOp2;
`ifdef FWD_STATS_EN
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FwdCount;
`endif

    // The pipeline control logic drives the ID fields; the hazard unit answers.
    modport master (
        output ID_Valid, ID_Src1, ID_Src2, ID_UsesSrc2, ID_Dest, ID_WB_En, ID_MemRead, Flush,
        input  Stall, forwardOp1, forwardOp2
`ifdef FWD_STATS_EN
        , input StallCount, FwdCount
`endif
    );

    modport slave (
        input  ID_Valid, ID_Src1, ID_Src2, ID_UsesSrc2, ID_Dest, ID_WB_En, ID_MemRead, Flush,
        output Stall, forwardOp1, forwardOp2
`ifdef FWD_STATS_EN
        , output StallCount, FwdCount
`endif
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Load-use stall detection and registered EX operand forward selects, driven by a shadow tag pipeline.
// Define FWD_STATS_EN to add the StallCount/FwdCount statistics counters.
module forward_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input logic                  clk,
    input logic                  rst_n,
    forward_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_read;
    } tag_t;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_WB  = 2'b01,
        SEL_EXM = 2'b10
    } fwd_sel_e;

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    tag_t              id_tag;
    tag_t              ex_tag;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_wb_en;

    logic     ex_hits_src1;
    logic     ex_hits_src2;
    logic     mem_hits_src1;
    logic     mem_hits_src2;
    logic     stall;
    logic     advance;
    fwd_sel_e next_op1;
    fwd_sel_e next_op2;
    fwd_sel_e load_op1;
    fwd_sel_e load_op2;
    fwd_sel_e fwd_op1_q;
    fwd_sel_e fwd_op2_q;

    // The WB stage is not kept: a producer reaches WB only after the selects needing it were
    // already taken from MEM, and the MEM stage never needs mem_read.
    always_comb begin
        ex_hits_src1  = ex_tag.valid && ex_tag.wb_en && (ex_tag.dest != ZERO_IDX)
                        && (ex_tag.dest == bus.ID_Src1);
        ex_hits_src2  = ex_tag.valid && ex_tag.wb_en && (ex_tag.dest != ZERO_IDX)
                        && (ex_tag.dest == bus.ID_Src2);
        mem_hits_src1 = mem_valid && mem_wb_en && (mem_dest != ZERO_IDX)
                        && (mem_dest == bus.ID_Src1);
        mem_hits_src2 = mem_valid && mem_wb_en && (mem_dest != ZERO_IDX)
                        && (mem_dest == bus.ID_Src2);
    end

    // A load in EX cannot supply its data to the next instruction yet; Flush overrides the hazard.
    always_comb begin
        stall   = 1'b0;
        advance = 1'b0;
        if (bus.ID_Valid && !bus.Flush && ex_tag.mem_read
            && (ex_hits_src1 || (bus.ID_UsesSrc2 && ex_hits_src2))) begin
            stall = 1'b1;
        end
        advance = bus.ID_Valid && !stall && !bus.Flush;
    end

    // The youngest producer wins, so the EX tag is checked before the MEM tag.
    always_comb begin
        next_op1 = SEL_RF;
        next_op2 = SEL_RF;
        if (ex_hits_src1) begin
            next_op1 = SEL_EXM;
        end else if (mem_hits_src1) begin
            next_op1 = SEL_WB;
        end
        if (bus.ID_UsesSrc2) begin
            if (ex_hits_src2) begin
                next_op2 = SEL_EXM;
            end else if (mem_hits_src2) begin
                next_op2 = SEL_WB;
            end
        end
        load_op1 = advance ? next_op1 : SEL_RF;
        load_op2 = advance ? next_op2 : SEL_RF;
    end

    always_comb begin
        id_tag          = '0;
        id_tag.valid    = 1'b1;
        id_tag.dest     = bus.ID_Dest;
        id_tag.wb_en    = bus.ID_WB_En;
        id_tag.mem_read = bus.ID_MemRead;
    end

    // MEM always follows EX; EX takes the ID instruction only when it really advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag    <= '0;
            mem_valid <= 1'b0;
            mem_dest  <= '0;
            mem_wb_en <= 1'b0;
            fwd_op1_q <= SEL_RF;
            fwd_op2_q <= SEL_RF;
        end else begin
            mem_valid <= ex_tag.valid;
            mem_dest  <= ex_tag.dest;
            mem_wb_en <= ex_tag.wb_en;
            ex_tag    <= advance ? id_tag : '0;
            fwd_op1_q <= load_op1;
            fwd_op2_q <= load_op2;
        end
    end

    assign bus.Stall      = stall;
    assign bus.forwardOp1 = fwd_op1_q;
    assign bus.forwardOp2 = fwd_op2_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] fwd_count;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            stall_count <= stall_count + CNT_W'(stall);
            fwd_count   <= fwd_count + CNT_W'(load_op1 != SEL_RF) + CNT_W'(load_op2 != SEL_RF);
        end
    end

    assign bus.StallCount = stall_count;
    assign bus.FwdCount   = fwd_count;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: a per-cycle model compare plus hand-computed spot checks.
// Also checks the statistics counters when FWD_STATS_EN is defined.
module tb_forward_hazard_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    forward_hazard_unit_if bus ();

    forward_hazard_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit v;
        int dest;
        bit wb;
        bit mr;
    } instr_t;

    // in_flight[0] is the instruction in EX, in_flight[1] the one in MEM.
    instr_t in_flight [2];
    int     exp_op1 = 0;
    int     exp_op2 = 0;
    bit     exp_stall;
    bit     issue;
    int     nxt1;
    int     nxt2;
`ifdef FWD_STATS_EN
    logic [31:0] exp_stalls = '0;
    logic [31:0] exp_fwds   = '0;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit produces(instr_t i, int r);
        return i.v && i.wb && (i.dest == r) && (r != 0);
    endfunction

    // 2 = result of the instruction one ahead (in EX), 1 = two ahead (in MEM), 0 = none.
    function automatic int youngestSource(int r);
        for (int age = 0; age < 2; age++) begin
            if (produces(in_flight[age], r)) return (age == 0) ? 2 : 1;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 2; a++) in_flight[a] = '{v: 1'b0, dest: 0, wb: 1'b0, mr: 1'b0};
            exp_op1 = 0;
            exp_op2 = 0;
`ifdef FWD_STATS_EN
            exp_stalls = '0;
            exp_fwds   = '0;
`endif
        end
        exp_stall = rst_n && bus.ID_Valid && !bus.Flush && in_flight[0].mr
                    && (produces(in_flight[0], int'(bus.ID_Src1))
                        || (bus.ID_UsesSrc2 && produces(in_flight[0], int'(bus.ID_Src2))));
        checkOutput("model_fwd1", bus.forwardOp1, exp_op1);
        checkOutput("model_fwd2", bus.forwardOp2, exp_op2);
        checkOutput("model_stall", bus.Stall, exp_stall);
`ifdef FWD_STATS_EN
        checkOutput("model_stall_count", bus.StallCount, exp_stalls);
        checkOutput("model_fwd_count", bus.FwdCount, exp_fwds);
`endif
        if (rst_n) begin
            issue = bus.ID_Valid && !bus.Flush && !exp_stall;
            nxt1  = issue ? youngestSource(int'(bus.ID_Src1)) : 0;
            nxt2  = (issue && bus.ID_UsesSrc2) ? youngestSource(int'(bus.ID_Src2)) : 0;
`ifdef FWD_STATS_EN
            if (exp_stall) exp_stalls = exp_stalls + 32'd1;
            exp_fwds = exp_fwds + 32'(nxt1 != 0) + 32'(nxt2 != 0);
`endif
            in_flight[1] = in_flight[0];
            if (issue)
                in_flight[0] = '{v: 1'b1, dest: int'(bus.ID_Dest), wb: bus.ID_WB_En, mr: bus.ID_MemRead};
            else
                in_flight[0] = '{v: 1'b0, dest: 0, wb: 1'b0, mr: 1'b0};
            exp_op1 = nxt1;
            exp_op2 = nxt2;
        end
    end

    task automatic applyStimulus(input bit valid, input int src1, input int src2, input bit uses2,
                                 input int dest, input bit wb, input bit mr, input bit flush);
        @(posedge clk);
        #1;
        bus.ID_Valid    = valid;
        bus.ID_Src1     = 5'(src1);
        bus.ID_Src2     = 5'(src2);
        bus.ID_UsesSrc2 = uses2;
        bus.ID_Dest     = 5'(dest);
        bus.ID_WB_En    = wb;
        bus.ID_MemRead  = mr;
        bus.Flush       = flush;
        #1;
    endtask

    task automatic nop();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ID_Valid = 0; bus.ID_Src1 = '0; bus.ID_Src2 = '0; bus.ID_UsesSrc2 = 0;
        bus.ID_Dest = '0; bus.ID_WB_En = 0; bus.ID_MemRead = 0; bus.Flush = 0;
        #1;
        checkOutput("reset_fwd1", bus.forwardOp1, 0);
        checkOutput("reset_stall", bus.Stall, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // EX-to-EX: add r3, then sub r3,r4
        applyStimulus(1, 1, 2, 1, 3, 1, 0, 0);
        applyStimulus(1, 3, 4, 1, 8, 1, 0, 0);
        checkOutput("ex_fwd_nostall", bus.Stall, 0);
        nop();
        checkOutput("ex_fwd_op1", bus.forwardOp1, 2);
        checkOutput("ex_fwd_op2", bus.forwardOp2, 0);

        // Two producers of r5: the younger one wins
        applyStimulus(1, 1, 2, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 5, 1, 0, 0);
        applyStimulus(1, 5, 6, 1, 9, 1, 0, 0);
        nop();
        checkOutput("priority_op1", bus.forwardOp1, 2);

        // MEM-to-EX with an independent instruction between
        applyStimulus(1, 1, 2, 1, 10, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 11, 1, 0, 0);
        applyStimulus(1, 10, 12, 1, 12, 1, 0, 0);
        nop();
        checkOutput("mem_fwd_op1", bus.forwardOp1, 1);
        checkOutput("mem_fwd_op2", bus.forwardOp2, 0);

        // Load-use: lw r7, add r13 = r1 + r7
        applyStimulus(1, 1, 0, 0, 7, 1, 1, 0);
        applyStimulus(1, 1, 7, 1, 13, 1, 0, 0);
        checkOutput("loaduse_stall", bus.Stall, 1);
        applyStimulus(1, 1, 7, 1, 13, 1, 0, 0);
        checkOutput("loaduse_stall_drop", bus.Stall, 0);
        checkOutput("loaduse_bubble_op2", bus.forwardOp2, 0);
        nop();
        checkOutput("loaduse_op2", bus.forwardOp2, 1);
        checkOutput("loaduse_op1", bus.forwardOp1, 0);

        // Load to r0 never stalls or forwards
        applyStimulus(1, 1, 2, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 20, 1, 0, 0);
        checkOutput("zero_nostall", bus.Stall, 0);
        nop();
        checkOutput("zero_op1", bus.forwardOp1, 0);
        checkOutput("zero_op2", bus.forwardOp2, 0);

        // Immediate operand: Src2 field matches but is not read
        applyStimulus(1, 1, 2, 1, 14, 1, 0, 0);
        applyStimulus(1, 2, 14, 0, 22, 1, 0, 0);
        nop();
        checkOutput("imm_op2", bus.forwardOp2, 0);

        // Flush beats load-use hazard
        applyStimulus(1, 1, 1, 0, 15, 1, 1, 0);
        applyStimulus(1, 15, 0, 0, 23, 1, 0, 1);
        checkOutput("flush_nostall", bus.Stall, 0);
        nop();
        checkOutput("flush_bubble_op1", bus.forwardOp1, 0);

        // Chained loads: one stall per dependent load
        applyStimulus(1, 1, 0, 0, 16, 1, 1, 0);
        applyStimulus(1, 16, 0, 0, 17, 1, 1, 0);
        checkOutput("chain_stall1", bus.Stall, 1);
        applyStimulus(1, 16, 0, 0, 17, 1, 1, 0);
        checkOutput("chain_release1", bus.Stall, 0);
        applyStimulus(1, 17, 2, 1, 21, 1, 0, 0);
        checkOutput("chain_stall2", bus.Stall, 1);
        checkOutput("chain_load_op1", bus.forwardOp1, 1);
        applyStimulus(1, 17, 2, 1, 21, 1, 0, 0);
        checkOutput("chain_release2", bus.Stall, 0);
        nop();
        checkOutput("chain_op1", bus.forwardOp1, 1);

        // Reset mid-stall with forwarding active
        applyStimulus(1, 1, 2, 1, 19, 1, 0, 0);
        applyStimulus(1, 19, 0, 0, 18, 1, 1, 0);
        applyStimulus(1, 18, 3, 1, 24, 1, 0, 0);
        checkOutput("prereset_op1", bus.forwardOp1, 2);
        checkOutput("prereset_stall", bus.Stall, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_stall", bus.Stall, 0);
        checkOutput("async_reset_op1", bus.forwardOp1, 0);
        checkOutput("async_reset_op2", bus.forwardOp2, 0);
`ifdef FWD_STATS_EN
        checkOutput("async_reset_stall_count", bus.StallCount, 0);
        checkOutput("async_reset_fwd_count", bus.FwdCount, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Tail traffic after reset, checked by the model only
        applyStimulus(1, 1, 2, 1, 25, 1, 1, 0);
        applyStimulus(1, 25, 25, 1, 26, 1, 0, 0);
        applyStimulus(1, 25, 25, 1, 26, 1, 0, 0);
        applyStimulus(1, 26, 25, 1, 27, 1, 0, 0);
        nop();
        nop();
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Control-side counterpart of the EX-stage operand forwarding muxes.
- Shadows the destination tags of in-flight instructions through its own EX/MEM/WB tag pipeline.
- Produces registered per-operand forward selects, aligned with the instruction occupying EX.
- Detects load-use hazards and stalls IF/ID for one cycle while inserting an EX bubble.

Parameters:
REG_AW, 5, register-address width
ZERO_REG, 0, register index never forwarded and never hazarded (hardwired zero)
CNT_W, 32, width of statistics counters (used only with FWD_STATS_EN)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
ID_Valid  input  1  ID stage holds a real instruction
ID_Src1  input  REG_AW  ID source register 1
ID_Src2  input  REG_AW  ID source register 2
ID_UsesSrc2  input  1  Src2 is actually read (R-type/store); 0 = immediate
ID_Dest  input  REG_AW  ID destination register
ID_WB_En  input  1  ID instruction writes the register file
ID_MemRead  input  1  ID instruction is a load
Flush  input  1  branch taken; kill the ID instruction
Stall  output  1  combinational; hold PC and IF/ID, bubble EX
forwardOp1  output  2  registered select for operand 1 of the EX instruction
forwardOp2  output  2  registered select for operand 2 of the EX instruction
StallCount  output  CNT_W  present only with FWD_STATS_EN
FwdCount  output  CNT_W  present only with FWD_STATS_EN

Behaviour:
- Select encoding:
  - 2'b00: register-file/ID operand.
  - 2'b01: WB_Data.
  - 2'b10: EXE_MEM_Result.
  - 2'b11: never driven.
- Tag pipeline: three registered stages, EX, MEM and WB. Each stage holds {valid, dest, wb_en, mem_read}.
- Every cycle: WB <= MEM and MEM <= EX, unconditionally.
- EX stage load:
  - EX <= ID fields when ID_Valid && !Stall && !Flush.
  - Otherwise EX <= bubble (valid=0, wb_en=0, mem_read=0).
- Tag "writes r": valid && wb_en && dest==r && r!=ZERO_REG.
- Load-use hazard (combinational): Stall = ID_Valid && !Flush && EX.valid && EX.mem_read && EX.wb_en && EX.dest!=ZERO_REG && (EX.dest==ID_Src1 || (ID_UsesSrc2 && EX.dest==ID_Src2)).
- Forward select computation, at the edge where ID advances into EX:
  - Next forwardOpN = 2'b10 if the current EX tag writes SrcN.
  - Else 2'b01 if the current MEM tag writes SrcN.
  - Else 2'b00.
  - Youngest producer wins: 10 has priority over 01.
  - forwardOp2 is forced to 00 when ID_UsesSrc2=0.
- Bubble load into EX (stall, flush or !ID_Valid): both selects <= 00.
- Load-use resolution: the stall lasts exactly one cycle. On the next cycle the load sits in MEM and no longer matches EX, so Stall drops. The consumer then advances and gets select 01 (load in WB).
- Back-to-back loads: a chain of loads feeding each other stalls one cycle per dependent load.
- Flush and hazard in the same cycle: Flush wins. Stall=0 and a bubble enters EX.
- ID_Valid=0: Stall=0 and a bubble enters EX.
- Reset: asynchronous on rst_n low.
  - All tag stages go invalid; forwardOp1 = forwardOp2 = 00.
  - Stall evaluates 0, because EX is invalid.
  - Counters clear to 0.
  - Reset asserted mid-stall clears the stall immediately.
- Latency: selects are valid in the same cycle the instruction is in EX, i.e. one clock after ID presentation.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined:
  - StallCount increments on every clock with Stall=1.
  - FwdCount increments by 1 per clock for each next select (Op1, Op2) that is non-zero, so +0, +1 or +2.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-run with valid tags in flight -> forwardOp1=forwardOp2=00 and Stall=0 immediately, without a clock edge.
- EX-to-EX forward: issue add r3 (WB_En), then sub with Src1=r3, Src2=r4 -> in the sub's EX cycle forwardOp1=10, forwardOp2=00.
- MEM-to-EX forward and priority:
  - Issue add r5, add r5, then or with Src1=r5 -> forwardOp1=10 (youngest wins).
  - Insert an independent instruction between producer and consumer instead -> forwardOp1=01.
- Load-use: issue lw r7, then add with Src2=r7, UsesSrc2=1 -> Stall=1 for exactly one cycle with a bubble in EX (selects 00); next cycle the add reaches EX with forwardOp2=01.
- Zero register / immediates / flush:
  - Producer writes r0, consumer reads r0 -> selects 00, no stall.
  - Consumer with UsesSrc2=0 and Src2 field matching -> forwardOp2=00.
  - Load-use with Flush=1 -> Stall=0, bubble in EX.
- FWD_STATS_EN: two load-use stalls plus three two-operand forwards -> StallCount=2, FwdCount=6; rst_n low -> both 0.
